// File: rtl/simmem_rsp_slot_bank.sv
// Response bank for one AXI response channel: per-ID circular regions with burst
// reservation, sticky release enables and round-robin output with stall lock.

module simmem_rsp_region #(
  parameter int SlotsPerId   = 8,
  parameter int DataW        = 32,
  parameter int MaxBurstLenW = 3,
  localparam int PtrW        = $clog2(SlotsPerId)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    rsv_en,
  input  logic [MaxBurstLenW-1:0] rsv_len,
  input  logic                    in_en,
  input  logic [DataW-1:0]        in_data,
  input  logic                    pop_en,
  input  logic [SlotsPerId-1:0]   release_en,
  output logic [PtrW:0]           used,
  output logic [PtrW-1:0]         rsv_slot,
  output logic [PtrW-1:0]         head_slot,
  output logic                    has_unfilled,
  output logic                    head_ready,
  output logic [DataW-1:0]        head_data
);
  logic [PtrW:0]                    rsv_ptr, fill_ptr, out_ptr, pending;
  logic [SlotsPerId-1:0]            filled, rel, reserved;
  logic [SlotsPerId-1:0][DataW-1:0] data;

  assign used         = rsv_ptr - out_ptr;
  assign pending      = rsv_ptr - fill_ptr;
  assign rsv_slot     = rsv_ptr[PtrW-1:0];
  assign head_slot    = out_ptr[PtrW-1:0];
  assign has_unfilled = rsv_ptr != fill_ptr;
  assign head_ready   = filled[head_slot] & rel[head_slot];
  assign head_data    = data[head_slot];

  // A slot is reserved when its distance from the head is below the occupancy.
  for (genvar s = 0; s < SlotsPerId; s++) begin : g_rsvd
    assign reserved[s] = {1'b0, PtrW'(s) - head_slot} < used;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsv_ptr  <= '0;
      fill_ptr <= '0;
      out_ptr  <= '0;
    end else begin
      if (rsv_en) rsv_ptr <= rsv_ptr + (PtrW+1)'(rsv_len) + 1'b1;
      if (in_en)  fill_ptr <= fill_ptr + 1'b1;
      if (pop_en) out_ptr <= out_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filled <= '0;
      rel    <= '0;
    end else begin
      for (int s = 0; s < SlotsPerId; s++) begin
        if (pop_en && head_slot == PtrW'(s)) begin
          filled[s] <= 1'b0;
          rel[s]    <= 1'b0;
        end else begin
          if (in_en && fill_ptr[PtrW-1:0] == PtrW'(s)) filled[s] <= 1'b1;
          if (release_en[s] && reserved[s])            rel[s]    <= 1'b1;
        end
      end
    end
  end

  // Payload needs no reset: the filled flags gate its visibility.
  always_ff @(posedge clk_i) begin
    if (in_en) data[fill_ptr[PtrW-1:0]] <= in_data;
  end

  a_fill_le_rsv: assert property (@(posedge clk_i) disable iff (!rst_ni) pending <= used);
  a_in_legal:    assert property (@(posedge clk_i) disable iff (!rst_ni) in_en |-> has_unfilled);
endmodule

module simmem_rsp_slot_bank #(
  parameter int NumIds       = 4,
  parameter int SlotsPerId   = 8,
  parameter int DataW        = 32,
  parameter int MaxBurstLenW = 3,
  localparam int IdW         = $clog2(NumIds),
  localparam int PtrW        = $clog2(SlotsPerId),
  localparam int Capa        = NumIds * SlotsPerId,
  localparam int AddrW       = $clog2(Capa)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    rsv_valid_i,
  output logic                    rsv_ready_o,
  input  logic [IdW-1:0]          rsv_id_i,
  input  logic [MaxBurstLenW-1:0] rsv_burst_len_i,
  output logic [AddrW-1:0]        rsv_iid_o,
  input  logic [Capa-1:0]         release_en_i,
  output logic [Capa-1:0]         released_addr_onehot_o,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [IdW-1:0]          in_id_i,
  input  logic [DataW-1:0]        in_data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [IdW-1:0]          out_id_o,
  output logic [DataW-1:0]        out_data_o
);
  logic [NumIds-1:0][PtrW:0]      used;
  logic [NumIds-1:0][PtrW-1:0]    rsv_slot, head_slot;
  logic [NumIds-1:0][DataW-1:0]   head_data;
  logic [NumIds-1:0]              has_unfilled, eligible, rsv_en, in_en, pop_en;
  logic [PtrW:0]                  free, need;
  logic [IdW-1:0]                 rr_ptr, lock_id, arb_id, grant;
  logic                           lock, pop, rsv_fire, in_fire;

  assign free        = (PtrW+1)'(SlotsPerId) - used[rsv_id_i];
  assign need        = (PtrW+1)'(rsv_burst_len_i) + 1'b1;
  assign rsv_ready_o = free >= need;
  assign rsv_iid_o   = AddrW'({rsv_id_i, rsv_slot[rsv_id_i]});
  assign in_ready_o  = has_unfilled[in_id_i];
  assign rsv_fire    = rsv_valid_i & rsv_ready_o;
  assign in_fire     = in_valid_i & in_ready_o;

  for (genvar k = 0; k < NumIds; k++) begin : g_region
    assign rsv_en[k] = rsv_fire && rsv_id_i == IdW'(k);
    assign in_en[k]  = in_fire && in_id_i == IdW'(k);
    assign pop_en[k] = pop && grant == IdW'(k);

    simmem_rsp_region #(
      .SlotsPerId  (SlotsPerId),
      .DataW       (DataW),
      .MaxBurstLenW(MaxBurstLenW)
    ) u_region (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .rsv_en      (rsv_en[k]),
      .rsv_len     (rsv_burst_len_i),
      .in_en       (in_en[k]),
      .in_data     (in_data_i),
      .pop_en      (pop_en[k]),
      .release_en  (release_en_i[k*SlotsPerId +: SlotsPerId]),
      .used        (used[k]),
      .rsv_slot    (rsv_slot[k]),
      .head_slot   (head_slot[k]),
      .has_unfilled(has_unfilled[k]),
      .head_ready  (eligible[k]),
      .head_data   (head_data[k])
    );
  end

  // Scan downward so the nearest eligible ID after rr_ptr wins.
  always_comb begin
    arb_id = rr_ptr;
    for (int i = NumIds; i >= 1; i--) begin
      if (eligible[(int'(rr_ptr) + i) % NumIds]) arb_id = IdW'((int'(rr_ptr) + i) % NumIds);
    end
  end

  assign grant       = lock ? lock_id : arb_id;
  assign out_valid_o = |eligible;
  assign out_id_o    = grant;
  assign out_data_o  = head_data[grant];
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    released_addr_onehot_o = '0;
    if (pop) released_addr_onehot_o[AddrW'({grant, head_slot[grant]})] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr  <= '0;
      lock    <= 1'b0;
      lock_id <= '0;
    end else if (pop) begin
      rr_ptr <= grant;
      lock   <= 1'b0;
    end else if (out_valid_o) begin
      lock    <= 1'b1;
      lock_id <= grant;
    end
  end

  a_rel_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(released_addr_onehot_o));
  a_stall_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    out_valid_o && !out_ready_i |=> out_valid_o && $stable(out_data_o) && $stable(out_id_o));
endmodule

// File: tb/tb_simmem_rsp_slot_bank.sv
// Directed bench for simmem_rsp_slot_bank: a per-cycle vector table followed by
// hand sequences for burst wrap, out-of-order release, arbitration and reset.

module tb_simmem_rsp_slot_bank;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rsv_valid = 1'b0;
  logic        rsv_ready;
  logic [1:0]  rsv_id = '0;
  logic [2:0]  rsv_burst_len = '0;
  logic [4:0]  rsv_iid;
  logic [31:0] release_en = '0;
  logic [31:0] released_oh;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_id = '0;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_id;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  simmem_rsp_slot_bank #(
    .NumIds(4), .SlotsPerId(8), .DataW(32), .MaxBurstLenW(3)
  ) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .rsv_valid_i           (rsv_valid),
    .rsv_ready_o           (rsv_ready),
    .rsv_id_i              (rsv_id),
    .rsv_burst_len_i       (rsv_burst_len),
    .rsv_iid_o             (rsv_iid),
    .release_en_i          (release_en),
    .released_addr_onehot_o(released_oh),
    .in_valid_i            (in_valid),
    .in_ready_o            (in_ready),
    .in_id_i               (in_id),
    .in_data_i             (in_data),
    .out_valid_o           (out_valid),
    .out_ready_i           (out_ready),
    .out_id_o              (out_id),
    .out_data_o            (out_data)
  );

  typedef struct {
    logic        rv;   logic [1:0] rid; logic [2:0] rlen;
    logic        iv;   logic [1:0] iid; logic [31:0] idata;
    logic [31:0] rel;  logic ordy;
    logic        e_rrdy; logic [4:0] e_riid; logic e_irdy; logic e_ov;
    logic [1:0]  e_oid;  logic [31:0] e_odata; logic [31:0] e_oh;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(int rv, int rid, int rlen, int iv, int iid, logic [31:0] idata,
                              logic [31:0] rel, int ordy, int e_rrdy, int e_riid, int e_irdy,
                              int e_ov, int e_oid, logic [31:0] e_odata, logic [31:0] e_oh);
    vec_t v;
    v.rv = 1'(rv); v.rid = 2'(rid); v.rlen = 3'(rlen);
    v.iv = 1'(iv); v.iid = 2'(iid); v.idata = idata;
    v.rel = rel; v.ordy = 1'(ordy);
    v.e_rrdy = 1'(e_rrdy); v.e_riid = 5'(e_riid); v.e_irdy = 1'(e_irdy); v.e_ov = 1'(e_ov);
    v.e_oid = 2'(e_oid); v.e_odata = e_odata; v.e_oh = e_oh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rsv_valid = 1'b0; in_valid = 1'b0; release_en = '0; out_ready = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_idle_out(input string tag);
    chk({tag, " rsv_ready"}, 64'(rsv_ready), 64'(1));
    chk({tag, " in_ready"}, 64'(in_ready), 64'(0));
    chk({tag, " out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, " released"}, 64'(released_oh), 64'(0));
  endtask

  task automatic do_reset(input string tag);
    idle(); rsv_id = '0; in_id = '0;
    rst_n = 1'b0; #1;
    chk_idle_out(tag);
    chk({tag, " rsv_iid"}, 64'(rsv_iid), 64'(0));
    tick(); rst_n = 1'b1;
  endtask

  task automatic reserve(input int id, input int len, input int exp_iid);
    idle(); rsv_valid = 1'b1; rsv_id = 2'(id); rsv_burst_len = 3'(len); #1;
    chk("reserve rsv_ready", 64'(rsv_ready), 64'(1));
    chk("reserve rsv_iid", 64'(rsv_iid), 64'(exp_iid));
    tick(); idle();
  endtask

  task automatic push(input int id, input logic [31:0] d);
    idle(); in_valid = 1'b1; in_id = 2'(id); in_data = d; #1;
    chk("push in_ready", 64'(in_ready), 64'(1));
    tick(); idle();
  endtask

  task automatic rel(input logic [31:0] mask);
    idle(); release_en = mask; tick(); idle();
  endtask

  task automatic pop(input int id, input logic [31:0] d, input int slot);
    idle(); out_ready = 1'b1; #1;
    chk("pop out_valid", 64'(out_valid), 64'(1));
    chk("pop out_id", 64'(out_id), 64'(id));
    chk("pop out_data", 64'(out_data), 64'(d));
    chk("pop released", 64'(released_oh), 64'(32'd1 << slot));
    tick(); idle();
  endtask

  task automatic stalled(input int id, input logic [31:0] d);
    out_ready = 1'b0; #1;
    chk("stall out_valid", 64'(out_valid), 64'(1));
    chk("stall out_id", 64'(out_id), 64'(id));
    chk("stall out_data", 64'(out_data), 64'(d));
    chk("stall released", 64'(released_oh), 64'(0));
    tick(); idle();
  endtask

  initial begin
    //          rv rid len iv iid idata     rel           ordy rrdy riid irdy ov oid odata    oh
    vecs[0]  = mk(0, 0, 0, 0, 0, 32'h0,   32'h0,        0,   1,   0,   0,   0, 0, 32'h0,   32'h0);
    vecs[1]  = mk(1, 2, 0, 0, 0, 32'h0,   32'h0,        0,   1,   16,  0,   0, 0, 32'h0,   32'h0);
    vecs[2]  = mk(0, 2, 0, 1, 2, 32'hA5,  32'h0,        0,   1,   17,  1,   0, 0, 32'h0,   32'h0);
    vecs[3]  = mk(0, 0, 0, 0, 2, 32'h0,   32'h0001_0000, 0,  1,   0,   0,   0, 0, 32'h0,   32'h0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 32'h0,   32'h0,        0,   1,   0,   0,   1, 2, 32'hA5,  32'h0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 32'h0,   32'h0,        1,   1,   0,   0,   1, 2, 32'hA5,  32'h0001_0000);
    vecs[6]  = mk(0, 2, 0, 0, 0, 32'h0,   32'h0,        1,   1,   17,  0,   0, 0, 32'h0,   32'h0);
    vecs[7]  = mk(1, 0, 3, 0, 0, 32'h0,   32'h0,        0,   1,   0,   0,   0, 0, 32'h0,   32'h0);
    vecs[8]  = mk(1, 0, 3, 0, 0, 32'h0,   32'h0,        0,   1,   4,   1,   0, 0, 32'h0,   32'h0);
    vecs[9]  = mk(1, 0, 0, 0, 0, 32'h0,   32'h0,        0,   0,   0,   1,   0, 0, 32'h0,   32'h0);
    vecs[10] = mk(0, 0, 0, 1, 0, 32'h100, 32'h0,        0,   0,   0,   1,   0, 0, 32'h0,   32'h0);
    vecs[11] = mk(0, 0, 0, 0, 0, 32'h0,   32'h1,        0,   0,   0,   1,   0, 0, 32'h0,   32'h0);
    vecs[12] = mk(0, 0, 0, 0, 0, 32'h0,   32'h0,        1,   0,   0,   1,   1, 0, 32'h100, 32'h1);
    vecs[13] = mk(0, 0, 0, 0, 0, 32'h0,   32'h0,        0,   1,   0,   1,   0, 0, 32'h0,   32'h0);

    tick();
    do_reset("reset");

    for (int i = 0; i < 14; i++) begin
      rsv_valid = vecs[i].rv; rsv_id = vecs[i].rid; rsv_burst_len = vecs[i].rlen;
      in_valid = vecs[i].iv; in_id = vecs[i].iid; in_data = vecs[i].idata;
      release_en = vecs[i].rel; out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("vec%0d rsv_ready", i), 64'(rsv_ready), 64'(vecs[i].e_rrdy));
      chk($sformatf("vec%0d rsv_iid", i), 64'(rsv_iid), 64'(vecs[i].e_riid));
      chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(vecs[i].e_irdy));
      chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
      chk($sformatf("vec%0d released", i), 64'(released_oh), 64'(vecs[i].e_oh));
      if (vecs[i].e_ov) begin
        chk($sformatf("vec%0d out_id", i), 64'(out_id), 64'(vecs[i].e_oid));
        chk($sformatf("vec%0d out_data", i), 64'(out_data), 64'(vecs[i].e_odata));
      end
      tick();
    end

    // Burst wrap in region 1: move the pointers to 6, then a 4-beat burst wraps.
    do_reset("reset2");
    reserve(1, 5, 8);
    for (int i = 0; i < 6; i++) push(1, 32'h200 + 32'(i));
    rel(32'h0000_FF00);
    for (int i = 0; i < 6; i++) pop(1, 32'h200 + 32'(i), 8 + i);
    reserve(1, 3, 14);
    for (int i = 0; i < 4; i++) push(1, 32'hD0 + 32'(i));
    rel(32'h0000_FF00);
    pop(1, 32'hD0, 14);
    pop(1, 32'hD1, 15);
    pop(1, 32'hD2, 8);
    pop(1, 32'hD3, 9);
    // Slot 10 was unreserved when the mask above was applied, so it must not be released.
    reserve(1, 0, 10);
    push(1, 32'hEE);
    #1 chk("unreserved release ignored", 64'(out_valid), 64'(0));
    tick();

    // Out-of-order release on region 0; same-cycle reserve+input sees old pointers.
    do_reset("reset3");
    rsv_valid = 1'b1; rsv_id = 2'd0; rsv_burst_len = 3'd1; in_valid = 1'b1; in_id = 2'd0; #1;
    chk("same-cycle in_ready", 64'(in_ready), 64'(0));
    chk("same-cycle rsv_iid", 64'(rsv_iid), 64'(0));
    tick(); idle();
    push(0, 32'hA0);
    push(0, 32'hA1);
    rel(32'h2);
    #1 chk("ooo head blocked", 64'(out_valid), 64'(0));
    tick();
    rel(32'h1);
    pop(0, 32'hA0, 0);
    pop(0, 32'hA1, 1);
    #1 chk("ooo drained", 64'(out_valid), 64'(0));
    tick();

    // Round-robin between regions 0 and 3, then a locked stall while region 1 arrives.
    reserve(0, 3, 2);
    reserve(3, 3, 24);
    for (int i = 0; i < 4; i++) push(0, 32'h00 + 32'(i));
    for (int i = 0; i < 4; i++) push(3, 32'h30 + 32'(i));
    rel(32'hFFFF_FFFF);
    pop(3, 32'h30, 24);
    pop(0, 32'h00, 2);
    rsv_valid = 1'b1; rsv_id = 2'd1; rsv_burst_len = 3'd0;
    stalled(3, 32'h31);
    in_valid = 1'b1; in_id = 2'd1; in_data = 32'h1F;
    stalled(3, 32'h31);
    release_en = 32'h0000_0100;
    stalled(3, 32'h31);
    stalled(3, 32'h31);
    pop(3, 32'h31, 25);
    pop(0, 32'h01, 3);
    pop(1, 32'h1F, 8);
    pop(3, 32'h32, 26);
    out_ready = 1'b1; #1;
    chk("pre-reset out_id", 64'(out_id), 64'(0));
    chk("pre-reset out_data", 64'(out_data), 64'(32'h02));
    rst_n = 1'b0; #1;
    chk("mid-reset out_valid", 64'(out_valid), 64'(0));
    chk("mid-reset released", 64'(released_oh), 64'(0));
    chk("mid-reset rsv_ready", 64'(rsv_ready), 64'(1));
    tick(); idle(); rst_n = 1'b1;
    rsv_id = 2'd3; #1;
    chk_idle_out("post-reset");
    chk("post-reset rsv_iid", 64'(rsv_iid), 64'(24));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/simmem_rsp_slot_bank.md
Name: simmem_rsp_slot_bank

Overview:
- Parametrised response bank for one AXI response channel. Used for write responses (bursts of one beat) or read data (multi-beat bursts).
- Storage is split into NumIds per-ID circular regions. Each region holds responses in reservation order until the delay releaser enables them.
- Adds features the fixed-size banks lack:
  - burst reservation that wraps within a region;
  - sticky (latched) release enables;
  - round-robin output arbitration across IDs with the grant locked under backpressure.

Parameters:
- NumIds, 4: number of AXI IDs, one region each.
- SlotsPerId, 8: slots per region. Must be a power of two and ≥ 2^MaxBurstLenW.
- DataW, 32: width of the stored response payload.
- MaxBurstLenW, 3: width of the burst-length field. The field encodes beats − 1.
- Derived: IdW = $clog2(NumIds); PtrW = $clog2(SlotsPerId); Capa = NumIds·SlotsPerId; AddrW = $clog2(Capa).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- rsv_valid_i  in  1  reservation request
- rsv_ready_o  out  1  reservation can be accepted
- rsv_id_i  in  IdW  ID being reserved
- rsv_burst_len_i  in  MaxBurstLenW  beats − 1
- rsv_iid_o  out  AddrW  start slot of the reservation
- release_en_i  in  Capa  multi-hot release enable, one bit per slot
- released_addr_onehot_o  out  Capa  slot freed this cycle
- in_valid_i  in  1  response from the memory controller is valid
- in_ready_o  out  1  input response accepted
- in_id_i  in  IdW  ID of the input response
- in_data_i  in  DataW  input payload
- out_valid_o  out  1  output response valid
- out_ready_i  in  1  requester ready
- out_id_o  out  IdW  ID of the output response
- out_data_o  out  DataW  output payload

Behaviour:
- Single clock. Reset is asynchronous and active-low, as already decided.
- Reset state:
  - all pointers 0, all filled and release flags 0, round-robin pointer 0, lock 0.
  - Outputs after reset: rsv_ready_o=1, rsv_iid_o=k·SlotsPerId for rsv_id_i=k, in_ready_o=0, out_valid_o=0, released_addr_onehot_o=0.
- Per-region state for region k:
  - rsv_ptr, fill_ptr, out_ptr, each PtrW+1 bits (extra wrap bit).
  - used = rsv_ptr − out_ptr.
  - Per-slot storage: filled flag, rel flag, data register.
- Reservation:
  - rsv_ready_o = (SlotsPerId − used[rsv_id_i]) ≥ rsv_burst_len_i + 1. Combinational from registered state and inputs.
  - rsv_iid_o = rsv_id_i·SlotsPerId + rsv_ptr[PtrW-1:0].
  - On rsv_valid_i && rsv_ready_o: rsv_ptr += len + 1. Burst slots are consecutive modulo SlotsPerId.
  - A pop in the same cycle does not raise free space until the next cycle.
- Input:
  - in_ready_o = rsv_ptr[in_id_i] ≠ fill_ptr[in_id_i], i.e. a reserved, unfilled slot exists.
  - On handshake: the slot at fill_ptr gets data = in_data_i and filled = 1; fill_ptr += 1.
  - If the reservation and input handshakes hit the same region in the same cycle, in_ready_o uses pre-update pointers.
- Release:
  - release_en_i[s] sets rel[s] at the clock edge only if slot s is reserved (between out_ptr and rsv_ptr) and is not being popped this cycle. Otherwise the bit is ignored.
  - rel stays set until the slot is popped.
- Eligibility and arbitration:
  - Region k is eligible when its head slot (out_ptr) has filled=1 and rel=1.
  - Only heads are eligible, so per-ID order is preserved even if release arrives out of order.
  - Minimum latency is 1 cycle from the input handshake or release latch to out_valid_o.
- Output:
  - out_valid_o = any region eligible.
  - The grant is round-robin, starting after the last popped ID.
  - While out_valid_o && !out_ready_i, the grant, out_id_o and out_data_o are locked (lock register). Newly eligible IDs do not change them.
- Pop on out_valid_o && out_ready_i:
  - head slot gets filled=0 and rel=0;
  - out_ptr += 1; lock is cleared; round-robin pointer = granted ID;
  - released_addr_onehot_o bit for that slot = 1 in the same cycle (combinational), 0 otherwise.
- Reset mid-operation: all stored responses and reservations are discarded immediately and the outputs return to reset values.
- Assertions (verification):
  - no input handshake when in_ready_o=0;
  - at most one released_addr_onehot_o bit set;
  - out_data_o stable while stalled;
  - fill_ptr never passes rsv_ptr.

Test Plan:
- Reset, then idle → rsv_ready_o=1, in_ready_o=0, out_valid_o=0, released_addr_onehot_o=0.
- Single beat:
  - reserve id 2, len 0 → rsv_iid_o=16;
  - input id 2, data 0xA5 → in_ready_o=1 and accepted;
  - pulse release_en_i[16] → next cycle out_valid_o=1, out_id_o=2, out_data_o=0xA5;
  - handshake → released_addr_onehot_o[16]=1, then out_valid_o=0.
- Full and wrap:
  - id 0: reserve len 3 twice → used=8;
  - reserve id 0 len 0 → rsv_ready_o=0;
  - fill and release slot 0, pop → next cycle rsv_ready_o=1 and rsv_iid_o=0.
- Burst wrap:
  - advance region 1 so rsv_ptr=6, then reserve len 3 → rsv_iid_o=14;
  - 4 input beats D0–D3 fill slots 14, 15, 8, 9;
  - release all → output order D0, D1, D2, D3.
- Out-of-order release: id 0 has 2 filled slots; release slot 1 first → out_valid_o=0; release slot 0 → slot 0 then slot 1 are output.
- Arbitration and backpressure:
  - ids 0 and 3 continuously eligible with out_ready_i=1 → grants alternate 0, 3, 0, 3;
  - hold out_ready_i=0 for 3 cycles while id 1 becomes eligible → out_id_o and out_data_o unchanged;
  - assert rst_ni=0 mid-stream → out_valid_o=0 immediately.
